// File: rtl/alu_uart_sequencer_pkg.sv
// alu_defs: opcode encodings shared with the ALU, datapath widths and the
// state encoding of the UART-driven operand/opcode sequencer.
package alu_defs;

  localparam int NB_DATA = 8;
  localparam int NB_OP   = 6;

  localparam logic [NB_OP-1:0] OP_ADD = 6'd32;
  localparam logic [NB_OP-1:0] OP_SUB = 6'd34;
  localparam logic [NB_OP-1:0] OP_AND = 6'd36;
  localparam logic [NB_OP-1:0] OP_OR  = 6'd37;
  localparam logic [NB_OP-1:0] OP_XOR = 6'd38;
  localparam logic [NB_OP-1:0] OP_SRA = 6'd3;
  localparam logic [NB_OP-1:0] OP_SRL = 6'd2;
  localparam logic [NB_OP-1:0] OP_NOR = 6'd39;

  typedef enum logic [2:0] {
    ST_WAIT_A  = 3'd0,
    ST_WAIT_B  = 3'd1,
    ST_WAIT_OP = 3'd2,
    ST_EXEC    = 3'd3,
    ST_WAIT_TX = 3'd4
  } state_e;

endpackage

// File: rtl/alu_uart_sequencer_if.sv
// Bundle of the UART RX/TX and ALU-side signals around the sequencer.
// master: the sequencer itself; slave: UART pair + ALU (or a testbench).
interface alu_uart_sequencer_if;
  import alu_defs::*;

  logic [NB_DATA-1:0] i_rx_data;
  logic               i_rx_done;
  logic [NB_DATA-1:0] o_data_a;
  logic [NB_DATA-1:0] o_data_b;
  logic [NB_OP-1:0]   o_op;
  logic [NB_DATA-1:0] i_alu_result;
  logic [NB_DATA-1:0] o_tx_data;
  logic               o_tx_start;
  logic               i_tx_done;
  logic               o_busy;
  logic               o_op_error;

  modport master (
    input  i_rx_data, i_rx_done, i_alu_result, i_tx_done,
    output o_data_a, o_data_b, o_op, o_tx_data, o_tx_start, o_busy, o_op_error
  );

  modport slave (
    output i_rx_data, i_rx_done, i_alu_result, i_tx_done,
    input  o_data_a, o_data_b, o_op, o_tx_data, o_tx_start, o_busy, o_op_error
  );

endinterface

// File: rtl/alu_uart_sequencer_op_check.sv
// alu_op_check: flags whether an opcode is one the ALU implements.
module alu_op_check
  import alu_defs::*;
(
  input  logic [NB_OP-1:0] i_op,
  output logic             o_valid
);

  // Membership test against the eight supported opcodes
  always_comb begin
    o_valid = 1'b0;
    case (i_op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_SRA, OP_SRL, OP_NOR: o_valid = 1'b1;
      default:                        o_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_uart_sequencer.sv
// alu_uart_sequencer: collects operand A, operand B and opcode bytes from the
// UART receiver, presents them to the ALU and ships the result to the UART
// transmitter. Optional build macro ALU_OP_CHECK_EN rejects opcode bytes that
// do not map to a supported ALU operation (o_op_error pulses instead).
module alu_uart_sequencer
  import alu_defs::*;
(
  input  logic                 i_clock,
  input  logic                 i_reset,
  alu_uart_sequencer_if.master bus
);

  state_e             state_q, state_d;
  logic [NB_DATA-1:0] data_a_q, data_a_d;
  logic [NB_DATA-1:0] data_b_q, data_b_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic [NB_DATA-1:0] tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;
  logic               op_error_q, op_error_d;
  logic               op_ok;

`ifdef ALU_OP_CHECK_EN
  alu_op_check u_op_check (
    .i_op    (bus.i_rx_data[NB_OP-1:0]),
    .o_valid (op_ok)
  );
`else
  assign op_ok = 1'b1;
`endif

  // Next-state and register-update decode; bytes arriving while busy are dropped
  always_comb begin
    state_d    = state_q;
    data_a_d   = data_a_q;
    data_b_d   = data_b_q;
    op_d       = op_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    op_error_d = 1'b0;
    case (state_q)
      ST_WAIT_A: begin
        if (bus.i_rx_done) begin
          data_a_d = bus.i_rx_data;
          state_d  = ST_WAIT_B;
        end
      end
      ST_WAIT_B: begin
        if (bus.i_rx_done) begin
          data_b_d = bus.i_rx_data;
          state_d  = ST_WAIT_OP;
        end
      end
      ST_WAIT_OP: begin
        if (bus.i_rx_done) begin
          if (op_ok) begin
            op_d    = bus.i_rx_data[NB_OP-1:0];
            state_d = ST_EXEC;
          end else begin
            op_error_d = 1'b1;
          end
        end
      end
      ST_EXEC: begin
        // ALU result is combinational on the registered operands/opcode
        tx_data_d  = bus.i_alu_result;
        tx_start_d = 1'b1;
        state_d    = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (bus.i_tx_done) state_d = ST_WAIT_A;
      end
      default: state_d = ST_WAIT_A;
    endcase
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= ST_WAIT_A;
      data_a_q   <= '0;
      data_b_q   <= '0;
      op_q       <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      op_error_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_a_q   <= data_a_d;
      data_b_q   <= data_b_d;
      op_q       <= op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      op_error_q <= op_error_d;
    end
  end

  assign bus.o_data_a   = data_a_q;
  assign bus.o_data_b   = data_b_q;
  assign bus.o_op       = op_q;
  assign bus.o_tx_data  = tx_data_q;
  assign bus.o_tx_start = tx_start_q;
  assign bus.o_busy     = (state_q == ST_EXEC) || (state_q == ST_WAIT_TX);
  assign bus.o_op_error = op_error_q;

endmodule

// File: doc/alu_uart_sequencer.md
# alu_uart_sequencer

Sequencer that drives the ALU's operand/opcode load interface from a byte stream instead of buttons and switches. It collects three received bytes (operand A, operand B, opcode), presents them to the ALU, captures the result and hands it to a UART transmitter. It sits between the UART RX/TX pair and the ALU datapath in the top level.

## Interface
- NB_DATA, 8, operand/result width and UART byte width
- NB_OP, 6, opcode width taken from the low bits of the opcode byte
- i_clock  in  1  system clock, all state on rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_rx_data  in  NB_DATA  received byte, valid while i_rx_done is high
- i_rx_done  in  1  one-cycle strobe, one byte received
- o_data_a  out  NB_DATA  registered operand A to ALU
- o_data_b  out  NB_DATA  registered operand B to ALU
- o_op  out  NB_OP  registered opcode to ALU
- i_alu_result  in  NB_DATA  combinational ALU result for o_data_a/o_data_b/o_op
- o_tx_data  out  NB_DATA  byte to transmit, held stable until i_tx_done
- o_tx_start  out  1  one-cycle strobe requesting transmission
- i_tx_done  in  1  one-cycle strobe, transmission finished
- o_busy  out  1  high in EXEC and WAIT_TX
- o_op_error  out  1  one-cycle strobe, rejected opcode (only with ALU_OP_CHECK_EN)

## Operation
- States: WAIT_A, WAIT_B, WAIT_OP, EXEC, WAIT_TX. Reset state WAIT_A.
- WAIT_A: on i_rx_done, o_data_a <= i_rx_data, go WAIT_B.
- WAIT_B: on i_rx_done, o_data_b <= i_rx_data, go WAIT_OP.
- WAIT_OP: on i_rx_done, o_op <= i_rx_data[NB_OP-1:0], go EXEC. Upper byte bits ignored.
- EXEC: one cycle. o_tx_data <= i_alu_result, o_tx_start <= 1, go WAIT_TX.
- WAIT_TX: o_tx_start low after one cycle; on i_tx_done go WAIT_A.
- i_rx_done in EXEC or WAIT_TX: byte dropped, no state or register change.
- i_tx_done outside WAIT_TX: ignored.
- Operand and opcode registers keep their value until overwritten by the next corresponding byte. o_data_a changing in WAIT_A has no effect on o_tx_data.
- Supported opcodes: 32 ADD, 34 SUB, 36 AND, 37 OR, 38 XOR, 3 SRA, 2 SRL, 39 NOR.

## Timing
- Reset (i_reset low, asynchronous): o_data_a, o_data_b, o_op, o_tx_data = 0. o_tx_start, o_busy, o_op_error = 0. State WAIT_A. Reset mid-sequence discards all partial bytes. Release is synchronous to i_clock.
- Opcode strobe at cycle N: o_op valid at N+1 (EXEC). o_tx_start high and o_tx_data valid at N+2 only.
- Earliest i_tx_done accepted is N+2, the o_tx_start cycle. The sequencer is then in WAIT_A at N+3.
- Back-to-back i_rx_done on consecutive cycles is accepted in WAIT_A/WAIT_B/WAIT_OP.
- o_busy is a function of registered state only.

## Configuration
- ALU_OP_CHECK_EN defined:
  - In WAIT_OP, a byte whose low NB_OP bits are not one of the eight supported opcodes is rejected.
  - o_op is unchanged, o_op_error pulses for one cycle (the cycle after the strobe), and the state stays WAIT_OP.
  - Operands are retained.
- ALU_OP_CHECK_EN undefined:
  - Any opcode is accepted.
  - o_op_error is tied to 0.

## Structure
- Shared package/include alu_defs holds:
  - opcode localparams (OP_ADD=32, OP_SUB=34, OP_AND=36, OP_OR=37, OP_XOR=38, OP_SRA=3, OP_SRL=2, OP_NOR=39), shared with the ALU
  - the state encoding for this block
- One sub-module, alu_op_check: combinational, NB_OP input, 1-bit valid output. Instantiated only under ALU_OP_CHECK_EN.

## Test plan
- Reset: assert i_reset low mid-WAIT_B -> all outputs 0, state WAIT_A. Next bytes 0x05, 0x03, 0x20 (ALU adds) -> o_tx_data 0x08, o_tx_start exactly at opcode strobe +2.
- SUB wrap: bytes 0x03, 0x05, 0x22 -> o_tx_data 0xFE. No second o_tx_start until i_tx_done plus a new three-byte sequence.
- Drop while busy: i_rx_done with 0x7F during WAIT_TX -> o_data_a unchanged. After i_tx_done, next byte 0x10 loads o_data_a = 0x10.
- Opcode byte 0xE5 -> o_op = 0x25 (OR). Result 0xF0|0x0F = 0xFF transmitted.
- With ALU_OP_CHECK_EN, opcode byte 0x01 -> o_op_error one-cycle pulse, state WAIT_OP, no o_tx_start. Following 0x27 with A=0xF0, B=0x0F -> o_tx_data 0x00 (NOR). Without the macro, 0x01 is accepted and o_tx_start pulses.
- Back-to-back strobes on three consecutive cycles (0xAA, 0x55, 0x26) -> o_tx_data 0xFF (XOR) at third strobe +2. i_tx_done in that same cycle -> WAIT_A next cycle.
